link_game_ctrl: RTL and testbench

//  Top-level sequencer for the player-character datapath (link_char), the collision

---
 rtl/link_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_link_game_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/link_game_ctrl.sv
// link_game_ctrl
//   Top-level sequencer for the game. Once per frame tick it walks the
//   player-character datapath, the collision detector and the map renderer
//   through one update: register action, check collision, apply action,
//   draw map, draw character. Each wait state has a watchdog so that a hung
//   unit cannot stall the game.
//
// Parameters
//   FRAME_TICKS  clock cycles per game frame (>= 2)
//   TICK_W       width of the frame counter (2^TICK_W >= FRAME_TICKS)
//   TIMEOUT      max cycles spent in any wait state before forced advance
//   TMO_W        width of the wait counter (2^TMO_W >= TIMEOUT)
//
// Ports
//   clock            in   system clock
//   reset            in   synchronous, active-high reset
//   start            in   level; leaves S_RESET when high
//   collision_done   in   collision detector finished
//   map_done         in   map renderer finished
//   draw_done        in   character sprite finished drawing
//   init .. draw_char out one-hot state strobes (none high in S_RESET)
//   overrun_count    out  saturating count of ticks lost while one was pending
//   timeout_err      out  sticky; set when a wait state is force-advanced
module link_game_ctrl #(
    parameter int FRAME_TICKS = 833333,
    parameter int TICK_W      = 20,
    parameter int TIMEOUT     = 200000,
    parameter int TMO_W       = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       collision_done,
    input  logic       map_done,
    input  logic       draw_done,
    output logic       init,
    output logic       idle,
    output logic       reg_action,
    output logic       check_collision,
    output logic       apply_action,
    output logic       draw_map,
    output logic       draw_char,
    output logic [7:0] overrun_count,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_RESET,
        S_INIT,
        S_IDLE,
        S_REG,
        S_COLL,
        S_APPLY,
        S_MAP,
        S_CHAR
    } state_t;

    localparam logic [TICK_W-1:0] FRAME_LAST = TICK_W'(FRAME_TICKS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [TICK_W-1:0]  frame_cnt;
    logic [TMO_W-1:0]   wait_cnt;
    logic               pending;
    logic               tick;
    logic               in_wait;
    logic               wait_done;
    logic               timeout;
    logic               advance;

    // Strobe pattern {init, idle, reg, coll, apply, map, char} for a state.
    function automatic logic [6:0] strobes_for(input state_t s);
        logic [6:0] r;
        r = 7'b0000000;
        case (s)
            S_INIT:  r = 7'b1000000;
            S_IDLE:  r = 7'b0100000;
            S_REG:   r = 7'b0010000;
            S_COLL:  r = 7'b0001000;
            S_APPLY: r = 7'b0000100;
            S_MAP:   r = 7'b0000010;
            S_CHAR:  r = 7'b0000001;
            default: r = 7'b0000000;
        endcase
        return r;
    endfunction

    always_comb begin
        // The frame counter only runs once the game is out of reset/init.
        tick = (state != S_RESET) && (state != S_INIT) && (frame_cnt == FRAME_LAST);

        in_wait   = 1'b0;
        wait_done = 1'b0;
        case (state)
            S_COLL: begin
                in_wait   = 1'b1;
                wait_done = collision_done;
            end
            S_MAP: begin
                in_wait   = 1'b1;
                wait_done = map_done;
            end
            S_CHAR: begin
                in_wait   = 1'b1;
                wait_done = draw_done;
            end
            default: begin
                in_wait   = 1'b0;
                wait_done = 1'b0;
            end
        endcase

        // Watchdog fires on the last allowed cycle only if the unit is still busy.
        timeout = in_wait && !wait_done && (wait_cnt == TMO_LAST);
        advance = wait_done || timeout;

        state_nxt = state;
        case (state)
            S_RESET: if (start) state_nxt = S_INIT;
            S_INIT:  state_nxt = S_IDLE;
            S_IDLE:  if (tick || pending) state_nxt = S_REG;
            S_REG:   state_nxt = S_COLL;
            S_COLL:  if (advance) state_nxt = S_APPLY;
            S_APPLY: state_nxt = S_MAP;
            S_MAP:   if (advance) state_nxt = S_CHAR;
            S_CHAR:  if (advance) state_nxt = S_IDLE;
            default: state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_RESET;
            init          <= 1'b0;
            idle          <= 1'b0;
            reg_action    <= 1'b0;
            check_collision <= 1'b0;
            apply_action  <= 1'b0;
            draw_map      <= 1'b0;
            draw_char     <= 1'b0;
            frame_cnt     <= '0;
            wait_cnt      <= '0;
            pending       <= 1'b0;
            overrun_count <= 8'd0;
            timeout_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Strobes are loaded from the next state so they always match the
            // state register without a combinational decode on the outputs.
            {init, idle, reg_action, check_collision,
             apply_action, draw_map, draw_char} <= strobes_for(state_nxt);

            if ((state == S_RESET) || (state == S_INIT) || tick)
                frame_cnt <= '0;
            else
                frame_cnt <= frame_cnt + TICK_W'(1);

            // A tick seen in IDLE goes straight to REG, so it never sets pending.
            if ((state == S_IDLE) && (state_nxt == S_REG))
                pending <= 1'b0;
            else if (tick)
                pending <= 1'b1;

            if (tick && pending && (state != S_IDLE) && (overrun_count != 8'hFF))
                overrun_count <= overrun_count + 8'd1;

            // Any state change restarts the count, so every wait state is
            // entered with a zero count.
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + TMO_W'(1);

            if (timeout)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_link_game_ctrl.sv
module tb_link_game_ctrl;

    localparam logic [6:0] P_NONE  = 7'b0000000;
    localparam logic [6:0] P_INIT  = 7'b1000000;
    localparam logic [6:0] P_IDLE  = 7'b0100000;
    localparam logic [6:0] P_REG   = 7'b0010000;
    localparam logic [6:0] P_COLL  = 7'b0001000;
    localparam logic [6:0] P_APPLY = 7'b0000100;
    localparam logic [6:0] P_MAP   = 7'b0000010;
    localparam logic [6:0] P_CHAR  = 7'b0000001;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // DUT A: TIMEOUT=8
    logic       a_reset, a_start, a_coll_done, a_map_done, a_draw_done;
    logic       a_init, a_idle, a_reg, a_coll, a_apply, a_map, a_char;
    logic [7:0] a_overrun;
    logic       a_err;

    // DUT B: TIMEOUT=64
    logic       b_reset, b_start, b_coll_done, b_map_done, b_draw_done;
    logic       b_init, b_idle, b_reg, b_coll, b_apply, b_map, b_char;
    logic [7:0] b_overrun;
    logic       b_err;

    link_game_ctrl #(.FRAME_TICKS(16), .TICK_W(5), .TIMEOUT(8), .TMO_W(4)) dut_a (
        .clock(clock), .reset(a_reset), .start(a_start),
        .collision_done(a_coll_done), .map_done(a_map_done), .draw_done(a_draw_done),
        .init(a_init), .idle(a_idle), .reg_action(a_reg), .check_collision(a_coll),
        .apply_action(a_apply), .draw_map(a_map), .draw_char(a_char),
        .overrun_count(a_overrun), .timeout_err(a_err)
    );

    link_game_ctrl #(.FRAME_TICKS(16), .TICK_W(5), .TIMEOUT(64), .TMO_W(7)) dut_b (
        .clock(clock), .reset(b_reset), .start(b_start),
        .collision_done(b_coll_done), .map_done(b_map_done), .draw_done(b_draw_done),
        .init(b_init), .idle(b_idle), .reg_action(b_reg), .check_collision(b_coll),
        .apply_action(b_apply), .draw_map(b_map), .draw_char(b_char),
        .overrun_count(b_overrun), .timeout_err(b_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] obs(input bit sel);
        if (sel)
            return {b_init, b_idle, b_reg, b_coll, b_apply, b_map, b_char};
        return {a_init, a_idle, a_reg, a_coll, a_apply, a_map, a_char};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Count consecutive cycles the strobe pattern holds (bounded).
    task automatic dwell(input bit sel, input logic [6:0] pat, output int n);
        n = 0;
        while ((obs(sel) == pat) && (n < 200)) begin
            n++;
            step();
        end
    endtask

    // One update with all dones high: REG..CHAR each exactly one cycle.
    task automatic run_fast(input bit sel, input string tag);
        logic [6:0] seq [5];
        seq = '{P_REG, P_COLL, P_APPLY, P_MAP, P_CHAR};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_seq%0d", tag, i), 32'(obs(sel)), 32'(seq[i]));
            step();
        end
    endtask

    // Walk REG, COLL, APPLY one cycle each, leaving the DUT in MAP.
    task automatic to_map(input bit sel, input string tag);
        logic [6:0] seq [3];
        seq = '{P_REG, P_COLL, P_APPLY};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_pre%0d", tag, i), 32'(obs(sel)), 32'(seq[i]));
            step();
        end
        chk({tag, "_map"}, 32'(obs(sel)), 32'(P_MAP));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;
        a_reset = 1'b1; a_start = 1'b0;
        a_coll_done = 1'b1; a_map_done = 1'b1; a_draw_done = 1'b1;
        b_reset = 1'b1; b_start = 1'b0;
        b_coll_done = 1'b1; b_map_done = 1'b1; b_draw_done = 1'b1;
        step();
        step();

        // Reset state
        chk("a_rst_strobes", 32'(obs(0)), 32'(P_NONE));
        chk("a_rst_err", 32'(a_err), 32'd0);
        chk("a_rst_overrun", 32'(a_overrun), 32'd0);
        chk("b_rst_strobes", 32'(obs(1)), 32'(P_NONE));

        // Start: INIT for one cycle, then IDLE until the first tick
        a_reset = 1'b0; a_start = 1'b1;
        step();
        chk("a_init", 32'(obs(0)), 32'(P_INIT));
        step();
        chk("a_idle", 32'(obs(0)), 32'(P_IDLE));
        dwell(0, P_IDLE, n);
        chk("a_idle_first", 32'(n), 32'd16);
        run_fast(0, "a_fast1");
        dwell(0, P_IDLE, n);
        chk("a_idle_period", 32'(n), 32'd11);

        // draw_done stuck low: CHAR force-advanced after 8 cycles
        a_draw_done = 1'b0;
        to_map(0, "a_tmo");
        step();
        chk("a_err_before", 32'(a_err), 32'd0);
        dwell(0, P_CHAR, n);
        chk("a_char_dwell", 32'(n), 32'd8);
        chk("a_after_tmo", 32'(obs(0)), 32'(P_IDLE));
        chk("a_err_set", 32'(a_err), 32'd1);
        a_draw_done = 1'b1;
        dwell(0, P_IDLE, n);
        chk("a_idle_after_tmo", 32'(n), 32'd4);
        run_fast(0, "a_fast2");
        chk("a_err_sticky", 32'(a_err), 32'd1);
        chk("a_overrun_zero", 32'(a_overrun), 32'd0);

        // Reset pulsed while in MAP
        a_map_done = 1'b0;
        dwell(0, P_IDLE, n);
        chk("a_idle_pre_rst", 32'(n), 32'd11);
        to_map(0, "a_rstmap");
        step();
        chk("a_in_map", 32'(obs(0)), 32'(P_MAP));
        a_reset = 1'b1; a_start = 1'b0;
        step();
        chk("a_midrst_strobes", 32'(obs(0)), 32'(P_NONE));
        chk("a_midrst_err", 32'(a_err), 32'd0);
        chk("a_midrst_overrun", 32'(a_overrun), 32'd0);
        chk("a_midrst_pending", 32'(dut_a.pending), 32'd0);
        chk("a_midrst_frame", 32'(dut_a.frame_cnt), 32'd0);
        chk("a_midrst_wait", 32'(dut_a.wait_cnt), 32'd0);
        a_reset = 1'b0;
        step();
        chk("a_hold_reset", 32'(obs(0)), 32'(P_NONE));

        // DUT B: map_done delayed 20 cycles, one tick lands while busy
        b_reset = 1'b0; b_start = 1'b1;
        step();
        chk("b_init", 32'(obs(1)), 32'(P_INIT));
        step();
        dwell(1, P_IDLE, n);
        chk("b_idle_first", 32'(n), 32'd16);
        b_map_done = 1'b0;
        to_map(1, "b_d20");
        for (int i = 0; i < 19; i++) step();
        chk("b_d20_still_map", 32'(obs(1)), 32'(P_MAP));
        chk("b_d20_pending", 32'(dut_b.pending), 32'd1);
        b_map_done = 1'b1;
        step();
        chk("b_d20_char", 32'(obs(1)), 32'(P_CHAR));
        step();
        dwell(1, P_IDLE, n);
        chk("b_d20_idle", 32'(n), 32'd1);
        chk("b_d20_pending_clr", 32'(dut_b.pending), 32'd0);
        chk("b_d20_overrun", 32'(b_overrun), 32'd0);
        run_fast(1, "b_fast");
        dwell(1, P_IDLE, n);
        chk("b_idle_realign", 32'(n), 32'd2);

        // map_done delayed 40 cycles: two ticks while busy, one overrun
        b_map_done = 1'b0;
        to_map(1, "b_d40");
        for (int i = 0; i < 39; i++) step();
        chk("b_d40_still_map", 32'(obs(1)), 32'(P_MAP));
        b_map_done = 1'b1;
        step();
        chk("b_d40_char", 32'(obs(1)), 32'(P_CHAR));
        step();
        dwell(1, P_IDLE, n);
        chk("b_d40_idle", 32'(n), 32'd1);
        chk("b_d40_overrun", 32'(b_overrun), 32'd1);
        chk("b_d40_err", 32'(b_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
